// File: rtl/rgb_pkg.sv
// rgb_pkg: shared pattern enum, colour-bar table and pixel width for the pattern generator.
package rgb_pkg;
   localparam int RGB_W = 24;
   typedef enum logic [2:0] {
      P_BITWALK = 3'd0,
      P_BARS8   = 3'd1,
      P_GRAY    = 3'd2,
      P_CHECK   = 3'd3,
      P_BOX     = 3'd4
   } pat_e;
   localparam logic [RGB_W-1:0] BAR_COLORS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };
   function automatic pat_e next_pat(input pat_e p);
      return (p == P_BOX) ? P_BITWALK : pat_e'(p + 3'd1);
   endfunction
endpackage

// File: rtl/box_mover.sv
// box_mover: moving-box position and direction, stepped once per frame with bounce at the edges.
module box_mover #(
   parameter int H_ACTIVE = 480,
   parameter int V_ACTIVE = 272,
   parameter int BOX_SIZE = 32,
   parameter int BOX_STEP = 2
) (
   input  logic       rgb_clk,
   input  logic       rgb_rst_n,
   input  logic       init_i,
   input  logic       step_i,
   output logic [9:0] box_x_o,
   output logic [9:0] box_y_o
);
   localparam logic [9:0] X_LIM = 10'(H_ACTIVE - BOX_SIZE);
   localparam logic [9:0] Y_LIM = 10'(V_ACTIVE - BOX_SIZE);
   logic [9:0] x_q, y_q, x_d, y_d;
   logic       dx_q, dy_q, dx_d, dy_d;
   // Returns {direction, position}; clamps to the limit and reverses on overshoot.
   function automatic logic [10:0] bounce(input logic [9:0] p, input logic d, input logic [9:0] lim);
      logic [10:0] up;
      up = {1'b0, p} + 11'(BOX_STEP);
      return d ? ((up > {1'b0, lim}) ? {1'b0, lim} : {1'b1, up[9:0]})
               : ((p < 10'(BOX_STEP)) ? {1'b1, 10'd0} : {1'b0, p - 10'(BOX_STEP)});
   endfunction
   always_comb begin
      {dx_d, x_d} = init_i ? {1'b1, 10'd0} : step_i ? bounce(x_q, dx_q, X_LIM) : {dx_q, x_q};
      {dy_d, y_d} = init_i ? {1'b1, 10'd0} : step_i ? bounce(y_q, dy_q, Y_LIM) : {dy_q, y_q};
   end
   always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
      if (!rgb_rst_n) begin
         x_q  <= '0;
         y_q  <= '0;
         dx_q <= 1'b1;
         dy_q <= 1'b1;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         dx_q <= dx_d;
         dy_q <= dy_d;
      end
   end
   assign box_x_o = x_q;
   assign box_y_o = y_q;
endmodule

// File: rtl/rgb_pattern_gen.sv
// rgb_pattern_gen: two-stage registered test-pattern generator with frame-synchronous pattern selection.
module rgb_pattern_gen
   import rgb_pkg::*;
#(
   parameter int   H_ACTIVE       = 480,
   parameter int   V_ACTIVE       = 272,
   parameter logic VS_ACTIVE      = 1'b0,
   parameter int   FRAMES_PER_PAT = 120,
   parameter int   BOX_SIZE       = 32,
   parameter int   BOX_STEP       = 2
) (
   input  logic             rgb_clk,
   input  logic             rgb_rst_n,
   input  logic             in_hs,
   input  logic             in_vs,
   input  logic             in_de,
   input  logic [9:0]       in_x,
   input  logic [9:0]       in_y,
   input  logic             auto_mode,
   input  logic             key_next,
   output logic             out_hs,
   output logic             out_vs,
   output logic             out_de,
   output logic [RGB_W-1:0] out_rgb,
   output logic [2:0]       pat_id
);
   localparam int BW_W = H_ACTIVE / 24;
   localparam int B8_W = H_ACTIVE / 8;
   localparam int G_Q  = 256 / H_ACTIVE;
   localparam int G_R  = 256 % H_ACTIVE;
   pat_e              pat_q, pat_d;
   logic              vs_q, adv_req_q, adv_req_d, tick, adv;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [9:0]        bw_run_q, bw_run_d, b8_run_q, b8_run_d, box_x, box_y;
   logic [4:0]        bw_idx_q, bw_idx_d;
   logic [2:0]        b8_idx_q, b8_idx_d;
   logic [10:0]       g_acc_q, g_acc_d, g_step;
   logic [7:0]        g_val_q, g_val_d;
   logic              s1_hs_q, s1_vs_q, s1_de_q, s2_hs_q, s2_vs_q, s2_de_q, in_box;
   logic [RGB_W-1:0]  c_bw_q, c_b8_q, c_gray_q, c_chk_q, c_box_q, pix, s2_rgb_q;
   assign tick = (in_vs == VS_ACTIVE) && (vs_q != VS_ACTIVE);
   assign adv  = tick && (adv_req_q || key_next ||
                          (auto_mode && frame_cnt_q == 16'(FRAMES_PER_PAT - 1)));
   always_comb begin
      pat_d       = adv ? next_pat(pat_q) : pat_q;
      adv_req_d   = !adv && (adv_req_q || key_next);
      frame_cnt_d = (!auto_mode || adv) ? '0 : tick ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end
   // Run-length and Bresenham counters restart on every blanking gap, so x position is implicit.
   always_comb begin
      bw_run_d = (!in_de || bw_run_q == 10'(BW_W - 1)) ? '0 : bw_run_q + 10'd1;
      bw_idx_d = !in_de ? '0 : bw_idx_q + 5'(bw_run_q == 10'(BW_W - 1));
      b8_run_d = (!in_de || b8_run_q == 10'(B8_W - 1)) ? '0 : b8_run_q + 10'd1;
      b8_idx_d = !in_de ? '0 : b8_idx_q + 3'(b8_run_q == 10'(B8_W - 1));
      g_step   = g_acc_q + 11'(G_R);
      g_acc_d  = !in_de ? '0 : (g_step >= 11'(H_ACTIVE)) ? g_step - 11'(H_ACTIVE) : g_step;
      g_val_d  = !in_de ? '0 : g_val_q + 8'(G_Q) + 8'(g_step >= 11'(H_ACTIVE));
      in_box   = ({1'b0, in_x} >= {1'b0, box_x}) && ({1'b0, in_x} < {1'b0, box_x} + 11'(BOX_SIZE)) &&
                 ({1'b0, in_y} >= {1'b0, box_y}) && ({1'b0, in_y} < {1'b0, box_y} + 11'(BOX_SIZE));
      pix      = (pat_q == P_BITWALK) ? c_bw_q : (pat_q == P_BARS8) ? c_b8_q :
                 (pat_q == P_GRAY) ? c_gray_q : (pat_q == P_CHECK) ? c_chk_q : c_box_q;
   end
   box_mover #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP)
   ) u_box (
      .rgb_clk  (rgb_clk),
      .rgb_rst_n(rgb_rst_n),
      .init_i   (adv && pat_q == P_CHECK),
      .step_i   (tick && pat_q == P_BOX),
      .box_x_o  (box_x),
      .box_y_o  (box_y)
   );
   always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
      if (!rgb_rst_n) begin
         pat_q       <= P_BITWALK;
         vs_q        <= ~VS_ACTIVE;
         adv_req_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         pat_q       <= pat_d;
         vs_q        <= in_vs;
         adv_req_q   <= adv_req_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end
   always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
      if (!rgb_rst_n) begin
         {bw_run_q, bw_idx_q, b8_run_q, b8_idx_q, g_acc_q, g_val_q} <= '0;
         {c_bw_q, c_b8_q, c_gray_q, c_chk_q, c_box_q, s2_rgb_q}     <= '0;
         {s1_hs_q, s1_vs_q, s2_hs_q, s2_vs_q} <= {4{~VS_ACTIVE}};
         {s1_de_q, s2_de_q} <= 2'b00;
      end else begin
         bw_run_q <= bw_run_d;
         bw_idx_q <= bw_idx_d;
         b8_run_q <= b8_run_d;
         b8_idx_q <= b8_idx_d;
         g_acc_q  <= g_acc_d;
         g_val_q  <= g_val_d;
         c_bw_q   <= 24'h800000 >> bw_idx_q;
         c_b8_q   <= BAR_COLORS[b8_idx_q];
         c_gray_q <= {3{g_val_q}};
         c_chk_q  <= {RGB_W{in_x[4] ^ in_y[4]}};
         c_box_q  <= in_box ? 24'hFFFFFF : 24'h000080;
         {s1_hs_q, s1_vs_q, s1_de_q} <= {in_hs, in_vs, in_de};
         {s2_hs_q, s2_vs_q, s2_de_q} <= {s1_hs_q, s1_vs_q, s1_de_q};
         s2_rgb_q <= s1_de_q ? pix : '0;
      end
   end
   assign out_hs  = s2_hs_q;
   assign out_vs  = s2_vs_q;
   assign out_de  = s2_de_q;
   assign out_rgb = s2_rgb_q;
   assign pat_id  = pat_q;
endmodule

// File: tb/tb_rgb_pattern_gen.sv
// tb_rgb_pattern_gen: directed checks of patterns, frame-synchronous selection, box motion and reset.
module tb_rgb_pattern_gen;
   localparam int H = 480;
   logic        rgb_clk = 1'b0, rgb_rst_n = 1'b0;
   logic        in_hs = 1'b1, in_vs = 1'b1, in_de = 1'b0, auto_mode = 1'b0, key_next = 1'b0;
   logic [9:0]  in_x = '0, in_y = '0;
   logic        out_hs, out_vs, out_de;
   logic [23:0] out_rgb;
   logic [2:0]  pat_id;
   int          checks = 0, failures = 0;
   logic        p_hs = 1'b1, p_vs = 1'b1, p_de = 1'b0, c_hs = 1'b1, c_vs = 1'b1, c_de = 1'b0;
   logic [7:0]  prev_g;
   int          bx, by;
   logic        dx, dy;

   always #5 rgb_clk = ~rgb_clk;

   rgb_pattern_gen #(.FRAMES_PER_PAT(2)) dut (
      .rgb_clk(rgb_clk), .rgb_rst_n(rgb_rst_n),
      .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_x(in_x), .in_y(in_y),
      .auto_mode(auto_mode), .key_next(key_next),
      .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_rgb(out_rgb), .pat_id(pat_id)
   );

   // p_* holds the syncs driven one step earlier, which is what the outputs show after this step.
   task automatic step(input logic hs, input logic vs, input logic de, input int x, input int y);
      in_hs = hs; in_vs = vs; in_de = de; in_x = 10'(x); in_y = 10'(y);
      p_hs = c_hs; p_vs = c_vs; p_de = c_de;
      c_hs = hs; c_vs = vs; c_de = de;
      @(posedge rgb_clk); #1;
   endtask

   task automatic chk_sync(input string tag);
      checks++;
      assert ({out_hs, out_vs, out_de} === {p_hs, p_vs, p_de}) else begin
         failures++;
         $error("FAIL %s hs/vs/de got=%b exp=%b", tag, {out_hs, out_vs, out_de}, {p_hs, p_vs, p_de});
      end
   endtask

   task automatic chk(input string tag, input logic [23:0] er);
      checks++;
      assert (out_rgb === er) else begin
         failures++;
         $error("FAIL %s rgb got=%h exp=%h", tag, out_rgb, er);
      end
      chk_sync(tag);
   endtask

   task automatic chk_pat(input string tag, input logic [2:0] e);
      checks++;
      assert (pat_id === e) else begin
         failures++;
         $error("FAIL %s pat_id got=%0d exp=%0d", tag, pat_id, e);
      end
   endtask

   task automatic chk_rst(input string tag);
      checks++;
      assert ({out_hs, out_vs, out_de, out_rgb, pat_id} === {1'b1, 1'b1, 1'b0, 24'h0, 3'd0}) else begin
         failures++;
         $error("FAIL %s hs/vs/de/rgb/pat got=%b%b%b/%h/%0d exp=110/000000/0",
                tag, out_hs, out_vs, out_de, out_rgb, pat_id);
      end
   endtask

   task automatic frame();
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
   endtask

   task automatic key_frame();
      key_next = 1'b1;
      step(1, 1, 1, 3, 0);
      key_next = 1'b0;
      step(1, 1, 0, 0, 0);
      frame();
   endtask

   task automatic probe(input int x, input int y, input logic [23:0] e, input string tag);
      step(1, 1, 1, x, y);
      step(1, 1, 0, 0, 0);
      chk(tag, e);
   endtask

   task automatic run_line(input int y, input int cx, input logic [23:0] ce, input string tag);
      for (int x = 0; x <= H; x++) begin
         step(1, 1, x < H, x, y);
         if (x == cx + 1) chk(tag, ce);
      end
      step(0, 1, 0, 0, 0);
      chk({tag, "_blank"}, 24'h0);
      step(1, 1, 0, 0, 0);
      chk({tag, "_hs"}, 24'h0);
   endtask

   initial begin
      step(1, 1, 0, 0, 0);
      chk_rst("reset");
      step(1, 1, 0, 0, 0);
      rgb_rst_n = 1'b1;
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      frame();
      chk_pat("no_adv_manual", 3'd0);
      // bit walk, full line
      for (int x = 0; x <= H; x++) begin
         step(1, 1, x < H, x, 0);
         if (x == 1) chk("bw_x0", 24'h800000);
         if (x == 21) chk("bw_x20", 24'h400000);
         if (x == 41) chk("bw_x40", 24'h200000);
         if (x == H) chk("bw_x479", 24'h000001);
      end
      step(0, 1, 0, 0, 0);
      chk("bw_blank", 24'h0);
      step(1, 1, 0, 0, 0);
      chk("bw_hs_low", 24'h0);
      // key mid-frame only takes effect at the next tick
      frame();
      key_next = 1'b1;
      step(1, 1, 1, 10, 3);
      key_next = 1'b0;
      step(1, 1, 1, 11, 3);
      step(1, 1, 0, 0, 0);
      chk_pat("key_mid_hold", 3'd0);
      step(1, 0, 0, 0, 0);
      chk_pat("key_tick", 3'd1);
      step(1, 1, 0, 0, 0);
      run_line(1, 0, 24'hFFFFFF, "b8_x0");
      run_line(2, 60, 24'hFFFF00, "b8_x60");
      run_line(3, 120, 24'h00FFFF, "b8_x120");
      run_line(4, 419, 24'h0000FF, "b8_x419");
      run_line(5, 479, 24'h000000, "b8_x479");
      // key coincident with tick: one advance, nothing left pending
      key_next = 1'b1;
      step(1, 0, 0, 0, 0);
      key_next = 1'b0;
      chk_pat("key_coinc", 3'd2);
      step(1, 1, 0, 0, 0);
      frame();
      chk_pat("key_no_double", 3'd2);
      // gray ramp
      prev_g = 8'd0;
      for (int x = 0; x <= H; x++) begin
         step(1, 1, x < H, x, 7);
         if (x == 1) chk("gray_x0", 24'h000000);
         if (x == 241) chk("gray_x240", 24'h808080);
         if (x == H) chk("gray_x479", 24'hFFFFFF);
         if (x >= 1) begin
            checks++;
            assert (out_rgb[7:0] >= prev_g) else begin
               failures++;
               $error("FAIL gray_mono x=%0d got=%h prev=%h", x - 1, out_rgb[7:0], prev_g);
            end
            prev_g = out_rgb[7:0];
         end
      end
      // checkerboard
      key_frame();
      chk_pat("to_check", 3'd3);
      probe(0, 0, 24'h000000, "chk_0_0");
      probe(16, 0, 24'hFFFFFF, "chk_16_0");
      probe(16, 16, 24'h000000, "chk_16_16");
      probe(15, 16, 24'hFFFFFF, "chk_15_16");
      // moving box against a reference model
      key_frame();
      chk_pat("to_box", 3'd4);
      bx = 0; by = 0; dx = 1'b1; dy = 1'b1;
      probe(0, 0, 24'hFFFFFF, "box0_tl");
      probe(31, 31, 24'hFFFFFF, "box0_br");
      probe(32, 0, 24'h000080, "box0_right");
      probe(0, 32, 24'h000080, "box0_below");
      for (int f = 0; f < 300; f++) begin
         frame();
         if (dx) begin
            if (bx + 2 > 448) begin bx = 448; dx = 1'b0; end else bx = bx + 2;
         end else begin
            if (bx - 2 < 0) begin bx = 0; dx = 1'b1; end else bx = bx - 2;
         end
         if (dy) begin
            if (by + 2 > 240) begin by = 240; dy = 1'b0; end else by = by + 2;
         end else begin
            if (by - 2 < 0) begin by = 0; dy = 1'b1; end else by = by - 2;
         end
         probe(bx, by, 24'hFFFFFF, "box_tl");
         probe(bx + 31, by + 31, 24'hFFFFFF, "box_br");
         probe(bx + 32, by, 24'h000080, "box_right");
         probe(bx, by + 32, 24'h000080, "box_below");
         if (bx > 0) probe(bx - 1, by, 24'h000080, "box_left");
      end
      // auto cycling, two frames per pattern
      key_frame();
      chk_pat("box_to_bitwalk", 3'd0);
      auto_mode = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         frame();
         chk_pat("auto_tick", 3'((k / 2) % 5));
         step(1, 1, 1, 0, 0);
         step(1, 1, 1, 1, 0);
         step(1, 1, 0, 0, 0);
         chk_pat("auto_mid", 3'((k / 2) % 5));
      end
      auto_mode = 1'b0;
      // asynchronous reset during an active line
      key_frame();
      chk_pat("pre_reset", 3'd1);
      for (int x = 0; x < 30; x++) step(1, 1, 1, x, 9);
      rgb_rst_n = 1'b0;
      #1;
      chk_rst("rst_mid_line");
      step(1, 1, 1, 30, 9);
      chk_rst("rst_hold");
      rgb_rst_n = 1'b1;
      c_hs = 1'b1; c_vs = 1'b1; c_de = 1'b0;
      step(1, 1, 1, 31, 9);
      chk("rel_first_black", 24'h0);
      step(0, 1, 1, 32, 9);
      chk_sync("rel_de");
      step(1, 0, 0, 0, 0);
      chk_sync("rel_hs");
      step(1, 1, 0, 0, 0);
      chk_sync("rel_vs");
      step(1, 1, 0, 0, 0);
      chk_sync("rel_idle");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rgb_pattern_gen.md
# rgb_pattern_gen

Registered test-pattern generator sitting directly downstream of `rgb_timing` and upstream of the LCD pins. Consumes the timing generator's hs/vs/de and x/y counters, produces a 24-bit pixel from one of five selectable patterns, and delays the sync signals so all outputs stay cycle-aligned. Pattern changes take effect only at frame boundaries, so no frame tears. Auto-cycling and a `key_next` pulse drive pattern selection.

## Interface
Parameters:
- `H_ACTIVE`, 480, active pixels per line; must be a multiple of 24.
- `V_ACTIVE`, 272, active lines per frame.
- `VS_ACTIVE`, 1'b0, active level of `in_vs`.
- `FRAMES_PER_PAT`, 120, frames shown per pattern in auto mode (≥1).
- `BOX_SIZE`, 32, moving-box edge length in pixels.
- `BOX_STEP`, 2, box displacement per frame per axis.

Ports:
- `rgb_clk` in 1: pixel clock; the only clock.
- `rgb_rst_n` in 1: asynchronous, active-low reset.
- `in_hs`, `in_vs`, `in_de` in 1 each: timing from `rgb_timing`.
- `in_x`, `in_y` in 10 each: active-area coordinates, valid while `in_de`=1.
- `auto_mode` in 1: 1 = advance pattern every `FRAMES_PER_PAT` frames.
- `key_next` in 1: single-cycle, already-debounced request to advance the pattern.
- `out_hs`, `out_vs`, `out_de` out 1 each: inputs delayed by 2 cycles.
- `out_rgb` out 24: pixel, {R[7:0],G[7:0],B[7:0]}.
- `pat_id` out 3: currently displayed pattern, 0–4.

## Operation
- Frame tick: a one-cycle pulse on the first cycle `in_vs` equals `VS_ACTIVE` after having been inactive. Detect it with a registered copy of `in_vs`.
- Pattern FSM states: P_BITWALK(0) → P_BARS8(1) → P_GRAY(2) → P_CHECK(3) → P_BOX(4) → P_BITWALK.
  - `key_next` sets a sticky `adv_req`.
  - Advance at a frame tick if `adv_req`=1, or if `auto_mode`=1 and `frame_cnt` = `FRAMES_PER_PAT`-1.
  - On advance, clear `frame_cnt` and `adv_req`. Otherwise `frame_cnt` increments per frame tick. `frame_cnt` holds at 0 while `auto_mode`=0.
  - If `key_next` coincides with a frame tick, the tick advances once and `adv_req` remains clear. The key is consumed by that advance.
  - If both the auto and key conditions hold at one tick, advance exactly once.
- Patterns, computed for the pixel at (`in_x`,`in_y`):
  - P_BITWALK: 24 bars of width `H_ACTIVE`/24. Bar k outputs 24'h800000 >> k.
  - P_BARS8: 8 bars of width `H_ACTIVE`/8, in the order white, yellow, cyan, green, magenta, red, blue, black.
  - P_GRAY: g = floor(in_x·256/`H_ACTIVE`) on R=G=B. No divider: use a per-line Bresenham accumulator that is cleared when `in_de`=0. g=0 at x=0 and g=255 at x=`H_ACTIVE`-1.
  - P_CHECK: white when in_x[4]^in_y[4] is 1, else black.
  - P_BOX: white inside [box_x, box_x+`BOX_SIZE`) × [box_y, box_y+`BOX_SIZE`), else 24'h000080.
- Bar indices are derived from run-length counters that are cleared while `in_de`=0. No multipliers or dividers on the pixel path.
- Box motion:
  - Update at each frame tick while in P_BOX.
  - Each axis moves by ±`BOX_STEP`.
  - Bounce rule: if the next position would exceed `H_ACTIVE`-`BOX_SIZE` (or `V_ACTIVE`-`BOX_SIZE` for y), or go below 0, clamp to the limit and invert that axis's direction.
  - On entering P_BOX: box at (0,0), direction +x/+y.

## Timing
- Reset values:
  - `out_hs`, `out_vs`: ~`VS_ACTIVE`-style inactive levels, i.e. 1 for `VS_ACTIVE`=0.
  - `out_de`=0, `out_rgb`=0, `pat_id`=0.
  - FSM in P_BITWALK; `frame_cnt`=0, `adv_req`=0.
- Latency is exactly 2 `rgb_clk` cycles from inputs to all outputs.
  - Stage 1 registers the per-pattern candidate pixel and delayed syncs.
  - Stage 2 registers the mux output, gated so `out_rgb`=0 whenever `out_de`=0.
- `pat_id` updates in the cycle after the frame tick. The pattern used for pixels is sampled from the same register, so the whole following active region uses a single pattern.
- Reset asserted mid-frame: all outputs go to reset values immediately. After release, outputs are valid from the next cycle with the 2-cycle pipeline fill; the first output pixels are black because of the stage clear.

## Structure
- Package `rgb_pkg`:
  - pattern enum (P_BITWALK…P_BOX, 3 bits);
  - 8-colour bar constant table;
  - `RGB_W`=24.
- Sub-module `box_mover`: box position/direction registers and bounce logic, clocked by frame tick.
- Everything else lives in `rgb_pattern_gen`.

## Test plan
- Reset, then feed a 480×272 timing model. In P_BITWALK, expect after a 2-cycle lag:
  - x=0 → 24'h800000;
  - x=20 → 24'h400000;
  - x=479 → 24'h000001;
  - `out_de`=0 → 0.
- `auto_mode`=1, `FRAMES_PER_PAT`=2: `pat_id` follows 0,0,1,1,2,2,3,3,4,4,0, changing one cycle after each second frame tick, never mid-frame.
- `auto_mode`=0: `key_next` pulse mid-frame → `pat_id` increments only at the next frame tick. A pulse coincident with a tick → exactly one increment.
- P_GRAY line check:
  - x=0 → 000000;
  - x=240 → 808080;
  - x=479 → FFFFFF;
  - outputs monotonic non-decreasing across the line.
- P_BOX over 300 frames, checked against a reference model:
  - box_x reaches 448, then decreases;
  - box_y reaches 240, then decreases;
  - the box never leaves the active area.
- Assert `rgb_rst_n` during an active line → all outputs at reset values in the same cycle. After release, out_hs/vs/de equal the inputs delayed by 2 cycles.
